// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: opcodes, response bytes and FSM states shared by the UART register bridge
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WRITE,
        BUS_READ,
        READ_WAIT,
        SEND_RESP
    } state_e;

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte idle counter that flags an abandoned frame
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 260416
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic Clear,
    input  logic Run,
    output logic Expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    // count idle cycles while running; hold at the terminal value until the FSM leaves
    always_comb begin
        count_d = (Clear || !Run) ? '0 : ((count_q == LAST) ? count_q : count_q + W'(1));
    end

    // counter register
    always_ff @(posedge Clock) begin
        if (!ResetN) count_q <= '0;
        else         count_q <= count_d;
    end

    assign Expired = Run && !Clear && (count_q == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes W/R frames from the UART RX FIFO into register bus accesses and replies via TX
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 260416
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 RxEmpty,
    input  logic [DATA_BITS-1:0] ReadData,
    output logic                 ReadUart,
    input  logic                 TxFull,
    output logic                 WriteUart,
    output logic [DATA_BITS-1:0] WriteData,
    output logic [ADDR_BITS-1:0] RegAddr,
    output logic [7:0]           RegWrData,
    output logic                 RegWrEn,
    output logic                 RegRdEn,
    input  logic [7:0]           RegRdData,
    output logic                 Busy,
    output logic                 FrameErr,
    output logic [7:0]           ErrCount
);

    state_e                 state_q, state_d;
    logic                   is_write_q, is_write_d;
    logic [7:0]             resp_q, resp_d;
    logic                   read_uart_q, read_uart_d;
    logic                   write_uart_q, write_uart_d;
    logic [DATA_BITS-1:0]   write_data_q, write_data_d;
    logic [ADDR_BITS-1:0]   reg_addr_q, reg_addr_d;
    logic [7:0]             reg_wr_data_q, reg_wr_data_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   capture, run, expired, err_hit;
    logic [7:0]             rx_byte;

    // a byte is taken only when the previous pop strobe has had a cycle to update the FIFO flags
    assign capture     = (state_q == IDLE || state_q == GET_ADDR || state_q == GET_DATA) && !RxEmpty && !read_uart_q;
    assign run         = (state_q == GET_ADDR || state_q == GET_DATA);
    assign read_uart_d = capture;
    assign rx_byte     = ReadData[7:0];

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Clear  (capture),
        .Run    (run),
        .Expired(expired)
    );

    // next-state and datapath decode; a captured byte always beats a same-cycle timeout
    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        resp_d        = resp_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        write_data_d  = write_data_q;
        write_uart_d  = 1'b0;
        err_hit       = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                        is_write_d = (rx_byte == OP_WRITE);
                        state_d    = GET_ADDR;
                    end else begin
                        resp_d  = RSP_ERR;
                        err_hit = 1'b1;
                        state_d = SEND_RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (capture) begin
                    reg_addr_d = ReadData[ADDR_BITS-1:0];
                    state_d    = is_write_q ? GET_DATA : BUS_READ;
                end else if (expired) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (capture) begin
                    reg_wr_data_d = rx_byte;
                    state_d       = BUS_WRITE;
                end else if (expired) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            BUS_WRITE: begin
                resp_d  = RSP_ACK;
                state_d = SEND_RESP;
            end
            BUS_READ:  state_d = READ_WAIT;
            READ_WAIT: begin
                resp_d  = RegRdData;
                state_d = SEND_RESP;
            end
            SEND_RESP: begin
                if (!TxFull && !write_uart_q) begin
                    write_uart_d = 1'b1;
                    write_data_d = DATA_BITS'(resp_q);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        frame_err_d = err_hit;
        err_count_d = (err_hit && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // state and registered outputs; reset discards any partial frame
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q       <= IDLE;
            is_write_q    <= 1'b0;
            resp_q        <= '0;
            read_uart_q   <= 1'b0;
            write_uart_q  <= 1'b0;
            write_data_q  <= '0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            resp_q        <= resp_d;
            read_uart_q   <= read_uart_d;
            write_uart_q  <= write_uart_d;
            write_data_q  <= write_data_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign ReadUart  = read_uart_q;
    assign WriteUart = write_uart_q;
    assign WriteData = write_data_q;
    assign RegAddr   = reg_addr_q;
    assign RegWrData = reg_wr_data_q;
    assign RegWrEn   = (state_q == BUS_WRITE);
    assign RegRdEn   = (state_q == BUS_READ);
    assign Busy      = (state_q != IDLE);
    assign FrameErr  = frame_err_q;
    assign ErrCount  = err_count_q;

endmodule
